// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS I opcode, funct and REGIMM encodings shared by the execute datapath
package mips_isa_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LWL     = 6'h22;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_LWR     = 6'h26;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_load_format.sv
// rtl/mips_load_format.sv - little-endian byte/halfword/unaligned load alignment and extension
module mips_load_format
    import mips_isa_pkg::*;
(
    input  logic [31:0] instr_word,
    input  logic [31:0] eff_addr,
    input  logic [31:0] mem_readdata,
    input  logic [31:0] op2,
    output logic [31:0] load_data
);

    logic [5:0]  opcode;
    logic [1:0]  lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_bits;

    assign opcode      = instr_word[31:26];
    assign lane        = eff_addr[1:0];
    assign byte_sel    = mem_readdata[{lane, 3'b000} +: 8];
    assign half_sel    = lane[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    assign unused_bits = ^{instr_word[25:0], eff_addr[31:2]};

    always_comb begin
        load_data = 32'h0;
        case (opcode)
            OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {24'h0, byte_sel};
            OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_data = {16'h0, half_sel};
            OP_LW:  load_data = mem_readdata;
            // LWL/LWR merge the addressed memory bytes into the old rt value
            OP_LWL: begin
                case (lane)
                    2'd0:    load_data = {mem_readdata[7:0],  op2[23:0]};
                    2'd1:    load_data = {mem_readdata[15:0], op2[15:0]};
                    2'd2:    load_data = {mem_readdata[23:0], op2[7:0]};
                    default: load_data = mem_readdata;
                endcase
            end
            OP_LWR: begin
                case (lane)
                    2'd0:    load_data = mem_readdata;
                    2'd1:    load_data = {op2[31:24], mem_readdata[31:8]};
                    2'd2:    load_data = {op2[31:16], mem_readdata[31:16]};
                    default: load_data = {op2[31:8],  mem_readdata[31:24]};
                endcase
            end
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mips_exec_datapath.sv
// rtl/mips_exec_datapath.sv - MIPS I execute stage: ALU, branch compare, HI/LO unit, load formatting
module mips_exec_datapath
    import mips_isa_pkg::*;
#(
    parameter logic [31:0] HILO_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hl_enable,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] instr_word,
    input  logic [31:0] mem_readdata,
    output logic [31:0] result,
    output logic [31:0] hi_result,
    output logic [31:0] lo_result,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] eff_addr,
    output logic        b_flag,
    output logic [31:0] load_data
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        unused_fields;

    assign opcode        = instr_word[31:26];
    assign funct         = instr_word[5:0];
    assign shamt         = instr_word[10:6];
    assign rt            = instr_word[20:16];
    assign imm           = instr_word[15:0];
    assign imm_sext      = sign_ext16(imm);
    assign imm_zext      = {16'h0, imm};
    assign unused_fields = ^{instr_word[25:21], instr_word[15:11]};

    assign eff_addr = op1 + imm_sext;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product
    assign prod_s = {{32{op1[31]}}, op1} * {{32{op2[31]}}, op2};
    assign prod_u = {32'h0, op1} * {32'h0, op2};

    always_comb begin
        quot_s = 32'h0;
        rem_s  = 32'h0;
        quot_u = 32'h0;
        rem_u  = 32'h0;
        if (op2 != 32'h0) begin
            quot_s = $signed(op1) / $signed(op2);
            rem_s  = $signed(op1) % $signed(op2);
            quot_u = op1 / op2;
            rem_u  = op1 % op2;
        end
    end

    always_comb begin
        result = 32'h0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL:           result = op2 << shamt;
                    FN_SRL:           result = op2 >> shamt;
                    FN_SRA:           result = $signed(op2) >>> shamt;
                    FN_SLLV:          result = op2 << op1[4:0];
                    FN_SRLV:          result = op2 >> op1[4:0];
                    FN_SRAV:          result = $signed(op2) >>> op1[4:0];
                    FN_ADD, FN_ADDU:  result = op1 + op2;
                    FN_SUB, FN_SUBU:  result = op1 - op2;
                    FN_AND:           result = op1 & op2;
                    FN_OR:            result = op1 | op2;
                    FN_XOR:           result = op1 ^ op2;
                    FN_NOR:           result = ~(op1 | op2);
                    FN_SLT:           result = {31'h0, $signed(op1) < $signed(op2)};
                    FN_SLTU:          result = {31'h0, op1 < op2};
                    default:          result = 32'h0;
                endcase
            end
            OP_ADDI, OP_ADDIU: result = op1 + imm_sext;
            OP_SLTI:           result = {31'h0, $signed(op1) < $signed(imm_sext)};
            OP_SLTIU:          result = {31'h0, op1 < imm_sext};
            OP_ANDI:           result = op1 & imm_zext;
            OP_ORI:            result = op1 | imm_zext;
            OP_XORI:           result = op1 ^ imm_zext;
            OP_LUI:            result = {imm, 16'h0};
            default:           result = 32'h0;
        endcase
    end

    always_comb begin
        hi_result = hi_out;
        lo_result = lo_out;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                FN_MULT:  {hi_result, lo_result} = prod_s;
                FN_MULTU: {hi_result, lo_result} = prod_u;
                FN_DIV: begin
                    if (op2 != 32'h0) begin
                        hi_result = rem_s;
                        lo_result = quot_s;
                    end
                end
                FN_DIVU: begin
                    if (op2 != 32'h0) begin
                        hi_result = rem_u;
                        lo_result = quot_u;
                    end
                end
                FN_MTHI:  hi_result = op1;
                FN_MTLO:  lo_result = op1;
                default: begin
                    hi_result = hi_out;
                    lo_result = lo_out;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_out <= HILO_RESET;
            lo_out <= HILO_RESET;
        end else if (hl_enable) begin
            hi_out <= hi_result;
            lo_out <= lo_result;
        end
    end

    always_comb begin
        b_flag = 1'b0;
        case (opcode)
            OP_BEQ:  b_flag = (op1 == op2);
            OP_BNE:  b_flag = (op1 != op2);
            OP_BLEZ: b_flag = op1[31] || (op1 == 32'h0);
            OP_BGTZ: b_flag = !op1[31] && (op1 != 32'h0);
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BLTZAL: b_flag = op1[31];
                    RT_BGEZ, RT_BGEZAL: b_flag = !op1[31];
                    default:            b_flag = 1'b0;
                endcase
            end
            default: b_flag = 1'b0;
        endcase
    end

    mips_load_format u_load_format (
        .instr_word   (instr_word),
        .eff_addr     (eff_addr),
        .mem_readdata (mem_readdata),
        .op2          (op2),
        .load_data    (load_data)
    );

endmodule

// File: tb/tb_mips_exec_datapath.sv
// tb/tb_mips_exec_datapath.sv - directed scoreboard bench for mips_exec_datapath
module tb_mips_exec_datapath;

    localparam logic [31:0] RST_VAL = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset;
    logic        hl_enable;
    logic [31:0] op1, op2, instr_word, mem_readdata;
    logic [31:0] result, hi_result, lo_result, hi_out, lo_out, eff_addr, load_data;
    logic        b_flag;

    int passed = 0;
    int total  = 0;

    string       exp_tag[$];
    logic [31:0] exp_val[$];

    mips_exec_datapath #(.HILO_RESET(RST_VAL)) dut (
        .clk          (clk),
        .reset        (reset),
        .hl_enable    (hl_enable),
        .op1          (op1),
        .op2          (op2),
        .instr_word   (instr_word),
        .mem_readdata (mem_readdata),
        .result       (result),
        .hi_result    (hi_result),
        .lo_result    (lo_result),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .eff_addr     (eff_addr),
        .b_flag       (b_flag),
        .load_data    (load_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] sh);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd1, rt, imm};
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_tag.push_back(tag);
        exp_val.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] ev;
        total++;
        if (exp_val.size() == 0) begin
            $error("FAIL scoreboard_empty: got %h required an expected entry", obs);
        end else begin
            tag = exp_tag.pop_front();
            ev  = exp_val.pop_front();
            assert (obs === ev) passed++;
            else $error("FAIL %s: got %h required %h", tag, obs, ev);
        end
    endtask

    task automatic clock_hilo();
        hl_enable = 1'b1;
        @(posedge clk);
        #1;
        hl_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hl_enable = 1'b1;
        op1 = 32'd123; op2 = 32'd456; mem_readdata = 32'h0;
        instr_word = r_ins(6'h11, 5'd0);
        expect_val("reset_hi", RST_VAL);
        expect_val("reset_lo", RST_VAL);
        @(posedge clk); #1;
        check(hi_out); check(lo_out);
        reset = 1'b0; hl_enable = 1'b0;
        expect_val("hold_hi", RST_VAL);
        @(posedge clk); #1;
        check(hi_out);

        instr_word = i_ins(6'h09, 5'd2, 16'hFFFF); op1 = 32'h5;
        expect_val("addiu_result", 32'h4);
        expect_val("addiu_eff_addr", 32'h4);
        expect_val("addiu_load_data", 32'h0);
        #1; check(result); check(eff_addr); check(load_data);

        op1 = 32'hFFFF_FFFF; op2 = 32'h1;
        instr_word = r_ins(6'h2A, 5'd0); expect_val("slt", 32'h1); #1; check(result);
        instr_word = r_ins(6'h2B, 5'd0); expect_val("sltu", 32'h0); #1; check(result);
        instr_word = r_ins(6'h23, 5'd0); expect_val("subu", 32'hFFFF_FFFE); #1; check(result);
        instr_word = r_ins(6'h27, 5'd0); expect_val("nor", 32'h0); #1; check(result);
        op2 = 32'h8000_0010;
        instr_word = r_ins(6'h03, 5'd4); expect_val("sra", 32'hF800_0001); #1; check(result);
        instr_word = r_ins(6'h02, 5'd4); expect_val("srl", 32'h0800_0001); #1; check(result);
        op1 = 32'h0000_0023;
        instr_word = r_ins(6'h04, 5'd0); expect_val("sllv", 32'h0000_0080); #1; check(result);
        instr_word = i_ins(6'h0F, 5'd2, 16'hBEEF); expect_val("lui", 32'hBEEF_0000); #1; check(result);
        op1 = 32'h0000_0005;
        instr_word = i_ins(6'h0B, 5'd2, 16'hFFFF); expect_val("sltiu", 32'h1); #1; check(result);
        instr_word = i_ins(6'h0A, 5'd2, 16'hFFFF); expect_val("slti", 32'h0); #1; check(result);
        instr_word = i_ins(6'h0D, 5'd2, 16'h8000); expect_val("ori_zext", 32'h0000_8005); #1; check(result);
        instr_word = i_ins(6'h23, 5'd2, 16'h0000); expect_val("lw_result_zero", 32'h0); #1; check(result);

        op1 = 32'hFFFF_FFFE; op2 = 32'd3; instr_word = r_ins(6'h18, 5'd0);
        expect_val("mult_hi", 32'hFFFF_FFFF);
        expect_val("mult_lo", 32'hFFFF_FFFA);
        clock_hilo();
        check(hi_out); check(lo_out);

        op1 = 32'hFFFF_FFFF; op2 = 32'd2; instr_word = r_ins(6'h19, 5'd0);
        expect_val("multu_hi_result", 32'h1);
        expect_val("multu_lo_result", 32'hFFFF_FFFE);
        #1; check(hi_result); check(lo_result);

        op1 = 32'hFFFF_FFF9; op2 = 32'd2; instr_word = r_ins(6'h1A, 5'd0);
        expect_val("div_lo", 32'hFFFF_FFFD);
        expect_val("div_hi", 32'hFFFF_FFFF);
        clock_hilo();
        check(lo_out); check(hi_out);
        op2 = 32'd0;
        expect_val("div0_lo", 32'hFFFF_FFFD);
        expect_val("div0_hi", 32'hFFFF_FFFF);
        clock_hilo();
        check(lo_out); check(hi_out);

        op1 = 32'd7; op2 = 32'd2; instr_word = r_ins(6'h1B, 5'd0);
        expect_val("divu_hi_result", 32'h1);
        expect_val("divu_lo_result", 32'h3);
        #1; check(hi_result); check(lo_result);

        op1 = 32'h0000_002A; instr_word = r_ins(6'h13, 5'd0);
        expect_val("mtlo_lo", 32'h0000_002A);
        expect_val("mtlo_hi", 32'hFFFF_FFFF);
        clock_hilo();
        check(lo_out); check(hi_out);

        mem_readdata = 32'h80FF_7F01; op1 = 32'h0000_1002; op2 = 32'hAABB_CCDD;
        instr_word = i_ins(6'h20, 5'd2, 16'h0000); expect_val("lb", 32'hFFFF_FFFF); #1; check(load_data);
        instr_word = i_ins(6'h24, 5'd2, 16'h0000); expect_val("lbu", 32'h0000_00FF); #1; check(load_data);
        instr_word = i_ins(6'h21, 5'd2, 16'h0001); expect_val("lh_n3", 32'hFFFF_80FF); #1; check(load_data);
        instr_word = i_ins(6'h25, 5'd2, 16'hFFFE); expect_val("lhu_n0", 32'h0000_7F01); #1; check(load_data);
        instr_word = i_ins(6'h22, 5'd2, 16'hFFFF); expect_val("lwl_n1", 32'h7F01_CCDD); #1; check(load_data);
        instr_word = i_ins(6'h22, 5'd2, 16'h0001); expect_val("lwl_n3", 32'h80FF_7F01); #1; check(load_data);
        instr_word = i_ins(6'h26, 5'd2, 16'hFFFF); expect_val("lwr_n1", 32'hAA80_FF7F); #1; check(load_data);
        instr_word = i_ins(6'h26, 5'd2, 16'hFFFE); expect_val("lwr_n0", 32'h80FF_7F01); #1; check(load_data);
        instr_word = i_ins(6'h23, 5'd2, 16'h0000); expect_val("lw", 32'h80FF_7F01); #1; check(load_data);

        op1 = 32'h0; op2 = 32'h0;
        instr_word = i_ins(6'h01, 5'd17, 16'h0); expect_val("bgezal_zero", 32'h1); #1; check({31'h0, b_flag});
        instr_word = i_ins(6'h01, 5'd0, 16'h0);  expect_val("bltz_zero", 32'h0);   #1; check({31'h0, b_flag});
        instr_word = i_ins(6'h06, 5'd0, 16'h0);  expect_val("blez_zero", 32'h1);   #1; check({31'h0, b_flag});
        instr_word = i_ins(6'h07, 5'd0, 16'h0);  expect_val("bgtz_zero", 32'h0);   #1; check({31'h0, b_flag});
        op1 = 32'h8000_0000;
        instr_word = i_ins(6'h01, 5'd16, 16'h0); expect_val("bltzal_neg", 32'h1);  #1; check({31'h0, b_flag});
        op1 = 32'd5; op2 = 32'd5;
        instr_word = i_ins(6'h05, 5'd2, 16'h0);  expect_val("bne_equal", 32'h0);   #1; check({31'h0, b_flag});
        instr_word = i_ins(6'h04, 5'd2, 16'h0);  expect_val("beq_equal", 32'h1);   #1; check({31'h0, b_flag});
        instr_word = r_ins(6'h21, 5'd0);         expect_val("addu_no_branch", 32'h0); #1; check({31'h0, b_flag});

        op1 = 32'h1111_1111; instr_word = r_ins(6'h11, 5'd0);
        reset = 1'b1;
        expect_val("reset_en_hi", RST_VAL);
        expect_val("reset_en_lo", RST_VAL);
        clock_hilo();
        reset = 1'b0;
        check(hi_out); check(lo_out);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
